// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit pipelined CPU: datapath widths,
// opcode constants and the reset fetch address.
package cpu10_pkg;

   localparam int AW = 10;
   localparam int IW = 10;

   localparam logic [2:0] OP_BNE  = 3'b010;
   localparam logic [2:0] OP_JUMP = 3'b100;
   localparam logic [2:0] OP_BEQ  = 3'b101;
   localparam logic [2:0] OP_SYS  = 3'b001;
   localparam logic [1:0] FN_HALT = 2'b10;

   localparam logic [AW-1:0] RESET_PC = '0;

endpackage

// File: rtl/fq_ring_buffer.sv
// Storage array of the fetch queue: one write port, combinational read.
// Ports: clk_i, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port.
module fq_ring_buffer
#(
   parameter int DEPTH = 4,
   parameter int W     = 20
)
(
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   import cpu10_pkg::*;

   logic [W-1:0] mem_q [DEPTH];

   // Contents are never reset; the top gates everything it presents.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue between the ROM and the Fetch+Decode stage.
// Ports: clk/rst, halted/stall/redirect(+pc) control, rom_addr/rom_data, head out.
module instr_fetch_queue
#(
   parameter int DEPTH = 4,
   parameter int AW    = cpu10_pkg::AW,
   parameter int IW    = cpu10_pkg::IW
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     halted,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [AW-1:0]            redirect_pc,
   output logic [AW-1:0]            rom_addr,
   input  logic [IW-1:0]            rom_data,
   output logic                     instr_valid,
   output logic [IW-1:0]            instr,
   output logic [AW-1:0]            instr_pc,
   output logic [$clog2(DEPTH):0]   count
);

   import cpu10_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]    fpc_q, fpc_d;
   logic [PW-1:0]    rp_q, rp_d;
   logic [PW-1:0]    wp_q, wp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop, flush;
   logic [AW+IW-1:0] head;

   // A halted CPU cannot resolve a branch, so redirect is masked then.
   assign flush       = redirect & ~halted;
   assign instr_valid = (cnt_q != '0) & ~halted;
   assign pop         = instr_valid & ~stall & ~redirect;
   // A full queue may still accept when its head leaves this cycle.
   assign push        = ~halted & ~redirect
                      & ((cnt_q < CW'(DEPTH)) | pop);

   always_comb begin
      fpc_d = fpc_q;
      rp_d  = rp_q;
      wp_d  = wp_q;
      cnt_d = cnt_q;
      if (flush) begin
         fpc_d = redirect_pc;
         rp_d  = '0;
         wp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            wp_d  = wp_q + PW'(1);
            fpc_d = fpc_q + AW'(1);
         end
         if (pop) begin
            rp_d = rp_q + PW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q <= AW'(RESET_PC);
         rp_q  <= '0;
         wp_q  <= '0;
         cnt_q <= '0;
      end else begin
         fpc_q <= fpc_d;
         rp_q  <= rp_d;
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
      end
   end

   fq_ring_buffer #(
      .DEPTH (DEPTH),
      .W     (AW + IW)
   ) u_ring (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wp_q),
      .wdata_i ({fpc_q, rom_data}),
      .raddr_i (rp_q),
      .rdata_o (head)
   );

   assign rom_addr = fpc_q;
   assign count    = cnt_q;
   assign instr    = instr_valid ? head[IW-1:0]     : '0;
   assign instr_pc = instr_valid ? head[AW+IW-1:IW] : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_fetch_queue;

   logic       clk = 1'b0;
   logic       rst, halted, stall, redirect;
   logic [9:0] redirect_pc, rom_addr, rom_data, instr, instr_pc;
   logic       instr_valid;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   // Model: queue of PCs in flight plus the fetch PC.
   int mq[$];
   int mfpc = 0;

   always #5 clk = ~clk;

   // ROM[i] = i + 0x100
   assign rom_data = rom_addr + 10'h100;

   instr_fetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .halted      (halted),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .count       (count)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare the DUT with the model, then advance the model for the edge.
   always @(negedge clk) begin
      if (checking) begin
         bit ev;
         int epc;
         ev  = (mq.size() != 0) && !halted;
         epc = ev ? mq[0] : 0;
         chk("m_valid", int'(instr_valid), int'(ev));
         chk("m_pc",    int'(instr_pc),    epc);
         chk("m_instr", int'(instr),       ev ? ((epc + 256) % 1024) : 0);
         chk("m_count", int'(count),       mq.size());
         chk("m_rom",   int'(rom_addr),    mfpc);
         if (rst) begin
            mq.delete();
            mfpc = 0;
         end else if (halted) begin
         end else if (redirect) begin
            mq.delete();
            mfpc = int'(redirect_pc);
         end else begin
            int n;
            n = mq.size();
            if (ev && !stall) void'(mq.pop_front());
            if (n < 4 || (ev && !stall)) begin
               mq.push_back(mfpc);
               mfpc = (mfpc + 1) % 1024;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; halted = 1'b0; stall = 1'b0;
      redirect = 1'b0; redirect_pc = '0;
      tick();
      checking = 1'b1;
      tick();
      chk("rst_valid", int'(instr_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_rom",   int'(rom_addr), 0);
      chk("rst_pc",    int'(instr_pc), 0);
      chk("rst_instr", int'(instr), 0);

      // Startup and free run
      rst = 1'b0;
      tick();
      chk("start_valid", int'(instr_valid), 1);
      chk("start_pc",    int'(instr_pc), 0);
      chk("start_instr", int'(instr), 'h100);
      tick();
      chk("run_pc1", int'(instr_pc), 1);
      chk("run_cnt", int'(count), 1);
      tick();
      chk("run_pc2", int'(instr_pc), 2);

      // Stall six cycles with PC 2 at head
      stall = 1'b1;
      repeat (6) tick();
      chk("stall_cnt", int'(count), 4);
      chk("stall_rom", int'(rom_addr), 6);
      chk("stall_pc",  int'(instr_pc), 2);
      stall = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         chk("release_pc", int'(instr_pc), i);
         tick();
      end

      // Redirect from a full queue, then build 3 entries
      redirect = 1'b1; redirect_pc = 10'd20;
      tick();
      redirect = 1'b0;
      chk("rd20_cnt", int'(count), 0);
      chk("rd20_valid", int'(instr_valid), 0);
      tick();
      chk("rd20_pc", int'(instr_pc), 20);
      stall = 1'b1;
      tick();
      tick();
      chk("three_cnt", int'(count), 3);

      // Redirect with stall held: redirect wins
      redirect = 1'b1; redirect_pc = 10'd40;
      tick();
      redirect = 1'b0; stall = 1'b0;
      chk("rd40_cnt", int'(count), 0);
      chk("rd40_valid", int'(instr_valid), 0);
      tick();
      chk("rd40_pc", int'(instr_pc), 40);
      chk("rd40_cnt1", int'(count), 1);

      // Fetch PC wrap
      redirect = 1'b1; redirect_pc = 10'd1023;
      tick();
      redirect = 1'b0;
      tick();
      chk("wrap_pc0", int'(instr_pc), 1023);
      chk("wrap_ins", int'(instr), 'h0ff);
      tick();
      chk("wrap_pc1", int'(instr_pc), 0);
      tick();
      chk("wrap_pc2", int'(instr_pc), 1);

      // Halt with two entries queued; redirect ignored
      stall = 1'b1;
      tick();
      chk("pre_halt_cnt", int'(count), 2);
      halted = 1'b1; stall = 1'b0;
      redirect = 1'b1; redirect_pc = 10'd77;
      #1;
      chk("halt_valid", int'(instr_valid), 0);
      chk("halt_instr", int'(instr), 0);
      tick();
      tick();
      chk("halt_cnt", int'(count), 2);
      chk("halt_rom", int'(rom_addr), 3);
      halted = 1'b0; redirect = 1'b0;
      #1;
      chk("unhalt_pc", int'(instr_pc), 1);
      tick();
      chk("unhalt_pc2", int'(instr_pc), 2);

      // Reset while full, stalled and redirecting
      stall = 1'b1;
      repeat (4) tick();
      chk("full_cnt", int'(count), 4);
      rst = 1'b1; redirect = 1'b1; redirect_pc = 10'd300;
      tick();
      chk("rst2_cnt", int'(count), 0);
      chk("rst2_rom", int'(rom_addr), 0);
      chk("rst2_valid", int'(instr_valid), 0);
      rst = 1'b0; redirect = 1'b0; stall = 1'b0;
      tick();
      chk("restart_pc", int'(instr_pc), 0);
      chk("restart_ins", int'(instr), 'h100);
      tick();
      tick();
      chk("restart_pc2", int'(instr_pc), 2);

      @(posedge clk);
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
